// File: rtl/tail_light_pkg.sv
// ----------------------------------------------------------------------------
// tail_light_pkg
//   Shared types and constants for the Thunderbird tail-light sequencer.
//   - state_e   : sequencer states (idle, three left steps, three right
//                 steps, hazard)
//   - LAMP_*    : lamp bar patterns, bit 0 innermost lamp
//   - seq_lamp  : helper giving the turning-side pattern for a sequence step
// ----------------------------------------------------------------------------
package tail_light_pkg;

    typedef enum logic [2:0] {
        IDLE,
        L1,
        L2,
        L3,
        R1,
        R2,
        R3,
        HAZ
    } state_e;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_1   = 3'b001;
    localparam logic [2:0] LAMP_2   = 3'b011;
    localparam logic [2:0] LAMP_3   = 3'b111;

    // Pattern shown on the turning side for a given state (L and R mirror).
    function automatic logic [2:0] seq_lamp(input state_e s);
        logic [2:0] p;
        p = LAMP_OFF;
        unique case (s)
            L1, R1:   p = LAMP_1;
            L2, R2:   p = LAMP_2;
            L3, R3:   p = LAMP_3;
            HAZ:      p = LAMP_3;
            default:  p = LAMP_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sync2.sv
// ----------------------------------------------------------------------------
// sync2
//   Two-flop synchronizer for a single asynchronous switch input.
//   Ports:
//     clk   - system clock
//     reset - synchronous active-high reset, clears both flops
//     d     - asynchronous input
//     q     - synchronized output (2 clocks after d)
// ----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[0], d};
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/tail_light_seq.sv
// ----------------------------------------------------------------------------
// tail_light_seq
//   Thunderbird tail-light sequencer. Divides the upstream tick by
//   TICKS_PER_STEP into lamp steps and runs turn / hazard / idle patterns on
//   three left and three right lamps.
//   Optional feature macro: TAIL_BRAKE_EN (adds the brake input; brake lights
//   the dark side(s) every cycle, except in hazard).
//   Ports:
//     clk     - system clock (same as divider)
//     reset   - synchronous active-high reset
//     tick    - one-cycle enable pulse from the divider
//     left    - left-turn switch (async)
//     right   - right-turn switch (async)
//     hazard  - hazard switch (async)
//     brake   - brake switch (async), only with TAIL_BRAKE_EN
//     l_lamp  - left lamps, bit 0 innermost (LA)
//     r_lamp  - right lamps, bit 0 innermost (RA)
//     step    - one-cycle pulse in the cycle after each lamp-step event
// ----------------------------------------------------------------------------
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int unsigned TICKS_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
`ifdef TAIL_BRAKE_EN
    input  logic       brake,
`endif
    output logic [2:0] l_lamp,
    output logic [2:0] r_lamp,
    output logic       step
);

    localparam int unsigned PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic left_s;
    logic right_s;
    logic hazard_s;

    sync2 u_sync_left   (.clk(clk), .reset(reset), .d(left),   .q(left_s));
    sync2 u_sync_right  (.clk(clk), .reset(reset), .d(right),  .q(right_s));
    sync2 u_sync_hazard (.clk(clk), .reset(reset), .d(hazard), .q(hazard_s));

`ifdef TAIL_BRAKE_EN
    logic brake_s;
    sync2 u_sync_brake  (.clk(clk), .reset(reset), .d(brake),  .q(brake_s));
`endif

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          step_evt;

    always_comb begin
        step_evt = tick && (pcnt_q == PW'(TICKS_PER_STEP - 1));
        pcnt_d   = pcnt_q;
        if (step_evt) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (moves only on a step event)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (step_evt) begin
            unique case (state_q)
                IDLE: begin
                    if (hazard_s || (left_s && right_s)) begin
                        state_d = HAZ;
                    end else if (left_s) begin
                        state_d = L1;
                    end else if (right_s) begin
                        state_d = R1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                L1:      state_d = L2;
                L2:      state_d = L3;
                L3:      state_d = IDLE;
                R1:      state_d = R2;
                R2:      state_d = R3;
                R3:      state_d = IDLE;
                HAZ:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Lamps are derived from the next state so they change
    // on the same edge that ends the step-event cycle.
    // ------------------------------------------------------------------
    logic [2:0] l_lamp_d;
    logic [2:0] r_lamp_d;

    always_comb begin
        l_lamp_d = LAMP_OFF;
        r_lamp_d = LAMP_OFF;
        unique case (state_d)
            L1, L2, L3: l_lamp_d = seq_lamp(state_d);
            R1, R2, R3: r_lamp_d = seq_lamp(state_d);
            HAZ: begin
                l_lamp_d = LAMP_3;
                r_lamp_d = LAMP_3;
            end
            default: begin
                l_lamp_d = LAMP_OFF;
                r_lamp_d = LAMP_OFF;
            end
        endcase
`ifdef TAIL_BRAKE_EN
        // Brake lights whichever side is not sequencing; hazard already full.
        if (brake_s) begin
            unique case (state_d)
                IDLE: begin
                    l_lamp_d = LAMP_3;
                    r_lamp_d = LAMP_3;
                end
                L1, L2, L3: r_lamp_d = LAMP_3;
                R1, R2, R3: l_lamp_d = LAMP_3;
                default: ;
            endcase
        end
`endif
    end

    logic [2:0] l_lamp_q;
    logic [2:0] r_lamp_q;
    logic       step_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            l_lamp_q <= LAMP_OFF;
            r_lamp_q <= LAMP_OFF;
            step_q   <= 1'b0;
        end else begin
            l_lamp_q <= l_lamp_d;
            r_lamp_q <= r_lamp_d;
            step_q   <= step_evt;
        end
    end

    assign l_lamp = l_lamp_q;
    assign r_lamp = r_lamp_q;
    assign step   = step_q;

endmodule

// File: doc/tail_light_seq.md
# tail_light_seq

Tail-light sequencer for the Thunderbird signal design. Consumes the one-cycle `tick` pulse produced by the upstream clock divider and steps three left and three right lamps through turn, hazard and idle patterns. Sits directly downstream of the divider; its lamp outputs drive the board LEDs.

## Interface
Parameters:
- `TICKS_PER_STEP`, default 4: number of `tick` pulses per lamp step; legal range 1..255.

Ports (clock and reset first):
- `clk`  input  1  system clock, same clock as the divider.
- `reset`  input  1  synchronous, active-high reset.
- `tick`  input  1  one-cycle enable pulse from the divider; never high on consecutive cycles.
- `left`  input  1  left-turn switch, asynchronous.
- `right`  input  1  right-turn switch, asynchronous.
- `hazard`  input  1  hazard switch, asynchronous.
- `brake`  input  1  brake switch, asynchronous; present only with `TAIL_BRAKE_EN`.
- `l_lamp`  output  3  left lamps; bit 0 is innermost (LA), bit 2 is outermost (LC).
- `r_lamp`  output  3  right lamps; bit 0 is innermost (RA), bit 2 is outermost (RC).
- `step`  output  1  one-cycle pulse marking each lamp-step event, for debug and verification.

## Operation
- All switch inputs pass through a two-flop synchronizer before use.
- Prescaler `pcnt` has width max(1, $clog2(TICKS_PER_STEP)) and is reset to 0.
  - On each `tick`, `pcnt` increments.
  - A step event is `tick && pcnt == TICKS_PER_STEP-1`; on that event `pcnt` returns to 0.
  - With `TICKS_PER_STEP` = 1, every tick is a step event.
- The FSM changes state only on a step event. States: IDLE, L1, L2, L3, R1, R2, R3, HAZ.
- Transitions from IDLE, using synchronized inputs sampled on the step cycle (first matching row wins):
  - `hazard` high, or `left` and `right` both high: go to HAZ.
  - `left` high: go to L1.
  - `right` high: go to R1.
  - Otherwise: stay in IDLE.
- Sequence transitions: L1→L2→L3→IDLE, R1→R2→R3→IDLE, HAZ→IDLE.
  - A started sequence always completes; input changes mid-sequence are ignored.
  - If the request persists, the sequence restarts from IDLE, so IDLE lasts one step (the dark phase of the blink).
- Lamp patterns for the turning side (other side dark without `TAIL_BRAKE_EN`):
  - IDLE: 000 on both sides.
  - L1, L2, L3: `l_lamp` = 001, 011, 111.
  - R1, R2, R3: `r_lamp` = 001, 011, 111.
  - HAZ: 111 on both sides.

## Timing
- Reset values: state IDLE, `pcnt` 0, `l_lamp` 000, `r_lamp` 000, `step` 0, synchronizer flops 0.
- Reset wins over a coincident `tick`.
- Reset asserted mid-sequence forces IDLE with all lamps dark on the next edge; there is no resumption after reset.
- Lamps are registered and computed from the next state.
  - They change on the same clock edge that ends the step-event cycle.
  - Latency from `tick` high to lamp change is 1 clock.
- `step` is registered: high for exactly the one cycle after the step-event cycle.
- An input edge needs 2 clocks to reach the synchronized value. It is acted on only at the first step event after that.
- Inputs sampled between step events have no effect.

## Configuration
- `TAIL_BRAKE_EN` defined: the `brake` port exists and is synchronized like the other switches. `brake` is applied combinationally into the lamp registers every cycle, not only on step events:
  - While brake is high in IDLE, both sides show 111.
  - While brake is high in L1–L3, `r_lamp` = 111 and the left side sequences normally; R1–R3 are the mirror case.
  - In HAZ, brake has no effect.
  - A brake change reaches the lamps 3 clocks after the input edge (2 synchronizer clocks plus 1 register clock).
- `TAIL_BRAKE_EN` undefined: there is no `brake` port, and the non-turning side is always dark.

## Structure
- Package `tail_light_pkg` holds:
  - the state enum;
  - lamp pattern constants `LAMP_OFF` = 3'b000, `LAMP_1` = 3'b001, `LAMP_2` = 3'b011, `LAMP_3` = 3'b111.
- Sub-module `sync2`: a two-flop synchronizer, 1 bit wide, with `clk` and `reset` ports. One instance per switch.
- The prescaler, FSM and lamp registers live in `tail_light_seq`.

## Test plan
- Reset: hold `reset` for 3 cycles with `tick` pulsing → lamps 000, `step` 0, state IDLE throughout.
- Left turn, `TICKS_PER_STEP` = 2, `left` held high → `l_lamp` goes 001, 011, 111, 000, 001… changing every 2nd tick; `r_lamp` stays 000.
- `left` and `right` both high → both sides alternate 111/000 on every step event; L and R states are never entered.
- `right` pulsed for one step period only → full R1, R2, R3 sequence runs, then IDLE, with no restart.
- Reset asserted during L2 → next edge gives `l_lamp` 000; the first step after release with `left` still high gives 001.
- With `TAIL_BRAKE_EN`, `brake` and `left` both high → `r_lamp` 111 held steady while `l_lamp` steps 001, 011, 111.
